// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment capture path: segment bit positions and
// active-high (gfedcba) glyph patterns for hex digits 0-F plus accepted aliases.
package seven_segment_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] PAT_0 = 7'h3F;
  localparam logic [6:0] PAT_1 = 7'h06;
  localparam logic [6:0] PAT_2 = 7'h5B;
  localparam logic [6:0] PAT_3 = 7'h4F;
  localparam logic [6:0] PAT_4 = 7'h66;
  localparam logic [6:0] PAT_5 = 7'h6D;
  localparam logic [6:0] PAT_6 = 7'h7D;
  localparam logic [6:0] PAT_7 = 7'h07;
  localparam logic [6:0] PAT_8 = 7'h7F;
  localparam logic [6:0] PAT_9 = 7'h67;
  localparam logic [6:0] PAT_A = 7'h77;
  localparam logic [6:0] PAT_B = 7'h7C;
  localparam logic [6:0] PAT_C = 7'h39;
  localparam logic [6:0] PAT_D = 7'h5E;
  localparam logic [6:0] PAT_E = 7'h79;
  localparam logic [6:0] PAT_F = 7'h71;
  localparam logic [6:0] PAT_7_ALT = 7'h27;
  localparam logic [6:0] PAT_9_ALT = 7'h6F;

  localparam logic [6:0] BLANK   = 7'h00;
  localparam logic [6:0] BLANK_N = 7'h7F;

endpackage

// File: rtl/seven_segment_lookup.sv
// Combinational reverse glyph table: active-high segment pattern -> {hit, hex value}.
module seven_segment_lookup
  import seven_segment_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_hit,
  output logic [3:0] o_value
);

  // Table lookup; anything not listed is reported as a miss with value 0.
  always_comb begin
    o_hit   = 1'b1;
    o_value = 4'h0;
    case (i_pattern)
      PAT_0:     o_value = 4'h0;
      PAT_1:     o_value = 4'h1;
      PAT_2:     o_value = 4'h2;
      PAT_3:     o_value = 4'h3;
      PAT_4:     o_value = 4'h4;
      PAT_5:     o_value = 4'h5;
      PAT_6:     o_value = 4'h6;
      PAT_7:     o_value = 4'h7;
      PAT_7_ALT: o_value = 4'h7;
      PAT_8:     o_value = 4'h8;
      PAT_9:     o_value = 4'h9;
      PAT_9_ALT: o_value = 4'h9;
      PAT_A:     o_value = 4'hA;
      PAT_B:     o_value = 4'hB;
      PAT_C:     o_value = 4'hC;
      PAT_D:     o_value = 4'hD;
      PAT_E:     o_value = 4'hE;
      PAT_F:     o_value = 4'hF;
      default: begin
        o_hit   = 1'b0;
        o_value = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Samples a multiplexed active-low seven-segment bus, filters each digit dwell for
// stability and reconstructs the hex value, valid and error state of every digit.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   anodes,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   decode_err,
  output logic                    update
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_TARGET = CW'(STABLE_CYCLES);

  logic [6:0]              r_seg_s1, r_seg_s2, r_prev_seg;
  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2, r_prev_an;
  logic [CW-1:0]           r_cnt;

  logic [NUM_DIGITS-1:0]   w_an_act;
  logic                    w_onehot;
  logic [IW-1:0]           w_idx;
  logic                    w_same;
  logic [CW-1:0]           w_cnt_next;
  logic                    w_commit;
  logic                    w_hit;
  logic [3:0]              w_value;
  logic [6:0]              w_pattern;
  logic [4*NUM_DIGITS-1:0] w_next_digits;
  logic [NUM_DIGITS-1:0]   w_next_valid, w_next_err;
  logic                    w_changed;

  // Two-flop synchronizers, preset to the blanked (all-ones) bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= BLANK_N;
      r_seg_s2 <= BLANK_N;
      r_an_s1  <= {NUM_DIGITS{1'b1}};
      r_an_s2  <= {NUM_DIGITS{1'b1}};
    end else begin
      r_seg_s1 <= segments;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= anodes;
      r_an_s2  <= r_an_s1;
    end
  end

  assign w_an_act  = ~r_an_s2;
  assign w_onehot  = (w_an_act != '0) && ((w_an_act & (w_an_act - 1'b1)) == '0);
  assign w_pattern = ~r_seg_s2;

  // Position of the single active anode.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_idx = w_an_act[i] ? IW'(i) : w_idx;
    end
  end

  // A zero count means the previous sample is not part of the current dwell.
  assign w_same     = ({r_an_s2, r_seg_s2} == {r_prev_an, r_prev_seg}) && (r_cnt != '0);
  assign w_cnt_next = !w_same ? CW'(1) :
                      (r_cnt == CNT_TARGET) ? r_cnt : r_cnt + 1'b1;
  assign w_commit   = w_onehot && (w_cnt_next == CNT_TARGET) &&
                      !(w_same && (r_cnt == CNT_TARGET));

  seven_segment_lookup u_lookup (
    .i_pattern (w_pattern),
    .o_hit     (w_hit),
    .o_value   (w_value)
  );

  // Dwell stability counter and previous-sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_seg <= BLANK_N;
      r_prev_an  <= {NUM_DIGITS{1'b1}};
      r_cnt      <= '0;
    end else begin
      r_prev_seg <= r_seg_s2;
      r_prev_an  <= r_an_s2;
      if (clear || !w_onehot) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end
  end

  // Next per-digit state when the current dwell commits.
  always_comb begin
    w_next_digits = digits;
    w_next_valid  = digit_valid;
    w_next_err    = decode_err;
    if (w_commit) begin
      if (w_hit) begin
        w_next_digits[{w_idx, 2'b00} +: 4] = w_value;
        w_next_valid[w_idx]                = 1'b1;
        w_next_err[w_idx]                  = 1'b0;
      end else begin
        w_next_valid[w_idx] = 1'b0;
        w_next_err[w_idx]   = 1'b1;
      end
    end else begin
      w_next_digits = digits;
    end
  end

  assign w_changed = (w_next_digits != digits) || (w_next_valid != digit_valid) ||
                     (w_next_err != decode_err);

  // Registered outputs; clear overrides any commit on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      decode_err  <= '0;
      update      <= 1'b0;
    end else if (clear) begin
      digits      <= '0;
      digit_valid <= '0;
      decode_err  <= '0;
      update      <= 1'b0;
    end else begin
      digits      <= w_next_digits;
      digit_valid <= w_next_valid;
      decode_err  <= w_next_err;
      update      <= w_commit && w_changed;
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed plus randomized bench for seven_segment_capture against a history-based model.
module tb_seven_segment_capture;

  localparam int ND = 4;
  localparam int SC = 4;
  localparam logic [10:0] BLANKV = 11'h7FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [6:0]  segments = 7'h7F;
  logic [3:0]  anodes = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_valid, decode_err;
  logic        update;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;

  logic [10:0] pins_q[$];
  logic [10:0] seen_q[$];
  logic [15:0] m_digits = '0;
  logic [3:0]  m_valid = '0, m_err = '0;
  logic        m_update = 1'b0;
  logic [6:0]  pats[18];

  seven_segment_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .segments(segments), .anodes(anodes), .clear(clear),
    .digits(digits), .digit_valid(digit_valid), .decode_err(decode_err), .update(update)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    case (s)
      7'h3F: return 5'h10; 7'h06: return 5'h11; 7'h5B: return 5'h12; 7'h4F: return 5'h13;
      7'h66: return 5'h14; 7'h6D: return 5'h15; 7'h7D: return 5'h16; 7'h07: return 5'h17;
      7'h27: return 5'h17; 7'h7F: return 5'h18; 7'h67: return 5'h19; 7'h6F: return 5'h19;
      7'h77: return 5'h1A; 7'h7C: return 5'h1B; 7'h39: return 5'h1C; 7'h5E: return 5'h1D;
      7'h79: return 5'h1E; 7'h71: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("digits", {16'h0, digits}, {16'h0, m_digits});
    chk("digit_valid", {28'h0, digit_valid}, {28'h0, m_valid});
    chk("decode_err", {28'h0, decode_err}, {28'h0, m_err});
    chk("update", {31'h0, update}, {31'h0, m_update});
  endtask

  // A digit commits when the last SC synchronized samples are the same one-hot dwell
  // and the sample just before them was not.
  task automatic model_edge(input logic [3:0] an, input logic [6:0] seg, input logic clr);
    logic [10:0] seen;
    logic [3:0]  act;
    logic        commit;
    logic [4:0]  d;
    logic [15:0] nd;
    logic [3:0]  nv, ne;
    int          n, idx;
    pins_q.push_back({an, seg});
    if (pins_q.size() > 16) void'(pins_q.pop_front());
    seen = (pins_q.size() >= 3) ? pins_q[pins_q.size()-3] : BLANKV;
    seen_q.push_back(clr ? BLANKV : seen);
    if (seen_q.size() > 16) void'(seen_q.pop_front());
    act = ~seen[10:7];
    n = seen_q.size();
    commit = !clr && ($countones(act) == 1) && (n >= SC);
    if (commit) begin
      for (int j = 0; j < SC; j++) if (seen_q[n-1-j] != seen) commit = 1'b0;
      if (n > SC && seen_q[n-1-SC] == seen) commit = 1'b0;
    end
    if (clr) begin
      m_digits = '0; m_valid = '0; m_err = '0; m_update = 1'b0;
    end else if (commit) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (act[i]) idx = i;
      nd = m_digits; nv = m_valid; ne = m_err;
      d = ref_decode(~seen[6:0]);
      if (d[4]) begin
        nd[idx*4 +: 4] = d[3:0]; nv[idx] = 1'b1; ne[idx] = 1'b0;
      end else begin
        nv[idx] = 1'b0; ne[idx] = 1'b1;
      end
      m_update = (nd != m_digits) || (nv != m_valid) || (ne != m_err);
      m_digits = nd; m_valid = nv; m_err = ne;
    end else begin
      m_update = 1'b0;
    end
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic clr);
    anodes = an; segments = seg; clear = clr;
    @(posedge clk);
    model_edge(an, seg, clr);
    #1;
    compare_all();
    if (update === 1'b1) upd_cnt++;
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    for (int k = 0; k < cycles; k++) step(an, seg, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    segments = 7'($urandom); anodes = 4'($urandom);
    #2;
    pins_q.delete(); seen_q.delete();
    m_digits = '0; m_valid = '0; m_err = '0; m_update = 1'b0;
    compare_all();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
             7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h27, 7'h6F};

    // 1: reset with arbitrary inputs
    segments = 7'($urandom); anodes = 4'($urandom);
    #12;
    compare_all();
    chk("reset_digits", {16'h0, digits}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: single digit dwell, commit after the 6th edge, exactly one pulse
    upd_cnt = 0;
    hold(4'b1110, ~7'h5B, 5);
    chk("t2_before", {31'h0, digit_valid[0]}, 32'h0);
    step(4'b1110, ~7'h5B, 1'b0);
    chk("t2_digit", {28'h0, digits[3:0]}, 32'h2);
    chk("t2_valid", {31'h0, digit_valid[0]}, 32'h1);
    hold(4'b1110, ~7'h5B, 4);
    chk("t2_pulses", upd_cnt, 32'd1);

    // 3: scan 1,2,3,4 twice
    for (int d = 0; d < 4; d++) hold(~(4'b0001 << d), ~pats[d+1], 8);
    chk("t3_digits", {16'h0, digits}, 32'h4321);
    chk("t3_valid", {28'h0, digit_valid}, 32'hF);
    upd_cnt = 0;
    for (int d = 0; d < 4; d++) hold(~(4'b0001 << d), ~pats[d+1], 8);
    chk("t3_rescan_pulses", upd_cnt, 32'd0);

    // 4: unstable pattern and blanking produce no commit
    for (int r = 0; r < 4; r++) hold(4'b1101, (r % 2 == 0) ? ~7'h3F : ~7'h06, 3);
    hold(4'b1100, ~7'h3F, 8);
    hold(4'b1111, ~7'h3F, 8);
    chk("t4_digits", {16'h0, digits}, 32'h4321);

    // 5: miss on digit 2 keeps the old value
    hold(4'b1011, ~7'h06, 8);
    upd_cnt = 0;
    hold(4'b1011, ~7'h49, 8);
    chk("t5_err", {31'h0, decode_err[2]}, 32'h1);
    chk("t5_valid", {31'h0, digit_valid[2]}, 32'h0);
    chk("t5_digit", {28'h0, digits[11:8]}, 32'h1);
    chk("t5_pulses", upd_cnt, 32'd1);

    // 6: clear on the committing edge, then recommit; reset mid-dwell, then recommit
    hold(4'b0111, ~7'h6D, 5);
    step(4'b0111, ~7'h6D, 1'b1);
    chk("t6_clear", {16'h0, digits}, 32'h0);
    chk("t6_clear_valid", {28'h0, digit_valid}, 32'h0);
    hold(4'b0111, ~7'h6D, 8);
    chk("t6_recommit", {16'h0, digits}, 32'h5000);
    hold(4'b1110, ~7'h27, 3);
    do_reset();
    chk("t6_reset_digits", {16'h0, digits}, 32'h0);
    hold(4'b1110, ~7'h27, 8);
    chk("t6_after_reset", {16'h0, digits}, 32'h0007);
    chk("t6_after_reset_valid", {28'h0, digit_valid}, 32'h1);

    // Randomized dwells: mostly table glyphs on one digit, with misses, blanking and clears
    for (int t = 0; t < 250; t++) begin
      logic [3:0] an;
      logic [6:0] pat;
      int         len;
      an  = ($urandom_range(0, 99) < 85) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      pat = ($urandom_range(0, 99) < 65) ? pats[$urandom_range(0, 17)] : 7'($urandom);
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) step(an, ~pat, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
